// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: two cache-side AR/R request ports plus the shared memory-side AXI4 read port.
// master is the arbiter's view; slave is the view of the caches and memory around it.
interface axi_rd_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [1:0]              m_arvalid, m_arready, m_rvalid, m_rready;
    logic [2*ADDR_WIDTH-1:0] m_araddr;
    logic [15:0]             m_arlen;
    logic [5:0]              m_arsize;
    logic [DATA_WIDTH-1:0]   m_rdata, s_rdata;
    logic [1:0]              m_rresp, s_rresp;
    logic                    m_rlast, s_rlast;
    logic                    s_arvalid, s_arready, s_rvalid, s_rready;
    logic [ADDR_WIDTH-1:0]   s_araddr;
    logic [7:0]              s_arlen;
    logic [2:0]              s_arsize;
    logic [3:0]              s_arid;

    modport master (
        input  m_arvalid, m_araddr, m_arlen, m_arsize, m_rready,
               s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
        output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
               s_arvalid, s_araddr, s_arlen, s_arsize, s_arid, s_rready
    );

    modport slave (
        output m_arvalid, m_araddr, m_arlen, m_arsize, m_rready,
               s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
        input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
               s_arvalid, s_araddr, s_arlen, s_arsize, s_arid, s_rready
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin, whole-burst arbiter sharing one AXI4 AR/R channel between ICache (0) and DCache (1).
module axi_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    axi_rd_arbiter_if.master bus,
    output logic             busy_o,
    output logic             err_o
);
    typedef enum logic [1:0] {IDLE, AR, R} state_t;
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
    state_t state, state_nxt, cur;
    logic grant, last_grant, win, first, beat;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0] len_q;
    logic [2:0] size_q;
    logic [8:0] cnt;

    always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;

    // cur forces IDLE outputs during reset; first blocks grants in the cycle right after it
    always_comb begin
        cur = rst ? IDLE : state;
        win = bus.m_arvalid[1] & (~bus.m_arvalid[0] | ~last_grant);
        bus.m_arready = (cur == IDLE && !first) ? bus.m_arvalid & (win ? 2'b10 : 2'b01) : 2'b00;
        bus.s_arvalid = cur == AR;
        bus.s_araddr = bus.s_arvalid ? addr_q : '0;
        bus.s_arlen = bus.s_arvalid ? len_q : '0;
        bus.s_arsize = bus.s_arvalid ? size_q : '0;
        bus.s_arid = {3'b000, grant & ~rst};
        bus.s_rready = cur == R && bus.m_rready[grant];
        bus.m_rvalid = (cur == R && bus.s_rvalid) ? (grant ? 2'b10 : 2'b01) : 2'b00;
        bus.m_rdata = cur == R ? bus.s_rdata : ZERO_DATA;
        bus.m_rresp = cur == R ? bus.s_rresp : 2'b00;
        bus.m_rlast = cur == R && bus.s_rlast;
        busy_o = cur != IDLE;
        beat = bus.s_rvalid && bus.s_rready;
        state_nxt = state == IDLE ? (|bus.m_arready ? AR : IDLE) :
                    state == AR ? (bus.s_arready ? R : AR) :
                    (beat && bus.s_rlast) ? IDLE : R;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {grant, cnt, err_o, addr_q, len_q, size_q} <= '0;
            last_grant <= 1'b1;
            first <= 1'b1;
        end else begin
            first <= 1'b0;
            if (|bus.m_arready) begin
                grant <= win;
                addr_q <= win ? bus.m_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.m_araddr[ADDR_WIDTH-1:0];
                len_q <= win ? bus.m_arlen[15:8] : bus.m_arlen[7:0];
                size_q <= win ? bus.m_arsize[5:3] : bus.m_arsize[2:0];
            end
            if (state == AR && bus.s_arready) cnt <= '0;
            else if (beat) cnt <= cnt + {8'd0, ~&cnt};
            if (beat && bus.s_rlast) last_grant <= grant;
            // a beat is wrong whenever rlast and "counter reached arlen" disagree
            if ((state == IDLE && bus.s_rvalid) || (beat && (bus.s_rlast != (cnt == {1'b0, len_q})))) err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed bench; stimulus pushes expected AR/R transfers, a monitor drains them at each handshake.
module tb_axi_rd_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy_o, err_o;
    int checks = 0;
    int errors = 0;
    int rbeats [2] = '{0, 0};
    logic [46:0] exp_ar [$];
    logic [35:0] exp_r [$];
    logic [46:0] ar_got, ar_exp;
    logic [35:0] r_got, r_exp;

    axi_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master),
        .busy_o(busy_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // scoreboard monitor: every slave AR handshake and every master R handshake consumes one expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.s_arvalid && bus.s_arready) begin
                ar_got = {bus.s_arid, bus.s_araddr, bus.s_arlen, bus.s_arsize};
                if (exp_ar.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ar_unexpected: got %0h, expected none", ar_got);
                end else begin
                    ar_exp = exp_ar.pop_front();
                    chk("ar_request", 64'(ar_got), 64'(ar_exp));
                end
            end
            for (int i = 0; i < 2; i++)
                if (bus.m_rvalid[i] && bus.m_rready[i]) begin
                    rbeats[i]++;
                    r_got = {i[0], bus.m_rdata, bus.m_rresp, bus.m_rlast};
                    if (exp_r.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL r_unexpected: got %0h, expected none", r_got);
                    end else begin
                        r_exp = exp_r.pop_front();
                        chk("r_beat", 64'(r_got), 64'(r_exp));
                    end
                end
        end
    end

    task automatic wait_arready(input int m);
        int n = 0;
        @(negedge clk);
        while (bus.m_arready == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("m_arready", bus.m_arready, m == 1 ? 2'b10 : 2'b01);
        chk("idle_busy", busy_o, 0);
        chk("ar_not_early", bus.s_arvalid, 0);
        @(posedge clk); #1;
        bus.m_arvalid[m] = 1'b0;
        @(negedge clk);
        chk("ar_next_cycle", bus.s_arvalid, 1);
        chk("busy_high", busy_o, 1);
        @(posedge clk); #1;
    endtask

    task automatic slave_ar(input int stall, input logic [31:0] addr, input logic [3:0] id);
        int n = 0;
        @(negedge clk);
        while (!bus.s_arvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s_arvalid", bus.s_arvalid, 1);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_arvalid", bus.s_arvalid, 1);
            chk("stall_araddr", bus.s_araddr, addr);
            chk("stall_arid", bus.s_arid, id);
            chk("stall_no_arready", bus.m_arready, 0);
        end
        @(posedge clk); #1;
        bus.s_arready = 1'b1;
        @(posedge clk); #1;
        bus.s_arready = 1'b0;
    endtask

    task automatic slave_r(input int m, input int n, input logic [31:0] base, input int last_at,
                           input int stall_at, input int stall_len);
        int k;
        logic [31:0] d;
        for (int b = 0; b < n; b++) begin
            d = base + 32'(b);
            bus.s_rvalid = 1'b1;
            bus.s_rdata = d;
            bus.s_rresp = d[1:0];
            bus.s_rlast = b == last_at;
            if (b == stall_at) begin
                bus.m_rready[m] = 1'b0;
                for (int i = 0; i < stall_len; i++) begin
                    @(negedge clk);
                    chk("bp_s_rready", bus.s_rready, 0);
                    @(posedge clk); #1;
                end
                bus.m_rready[m] = 1'b1;
            end
            exp_r.push_back({m[0], d, d[1:0], b == last_at});
            k = 0;
            @(negedge clk);
            while (!bus.s_rready && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("s_rready", bus.s_rready, 1);
            @(posedge clk); #1;
        end
        bus.s_rvalid = 1'b0;
        bus.s_rlast = 1'b0;
    endtask

    initial begin
        bus.m_arvalid = 2'b11;
        bus.m_araddr = {32'h2000_0040, 32'h1C00_0000};
        bus.m_arlen = {8'd3, 8'd3};
        bus.m_arsize = {3'd2, 3'd2};
        bus.m_rready = 2'b11;
        bus.s_arready = 1'b0;
        bus.s_rvalid = 1'b0;
        bus.s_rdata = '0;
        bus.s_rresp = '0;
        bus.s_rlast = 1'b0;
        exp_ar.push_back({4'd0, 32'h1C00_0000, 8'd3, 3'd2});
        exp_ar.push_back({4'd1, 32'h2000_0040, 8'd3, 3'd2});
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", bus.m_arready, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_arvalid", bus.s_arvalid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_arready", bus.m_arready, 0);
        chk("post_rst_busy", busy_o, 0);
        @(posedge clk); #1;
        // contention from reset: ICache first, four clean beats
        wait_arready(0);
        slave_ar(0, 32'h1C00_0000, 4'd0);
        slave_r(0, 4, 32'hA0, 3, -1, 0);
        chk("m0_beats", rbeats[0], 4);
        // ICache asks again while DCache still waits: DCache must win, under an AR stall and R backpressure
        bus.m_araddr[31:0] = 32'h1C00_0040;
        bus.m_arlen[7:0] = 8'd1;
        bus.m_arvalid[0] = 1'b1;
        exp_ar.push_back({4'd0, 32'h1C00_0040, 8'd1, 3'd2});
        wait_arready(1);
        slave_ar(5, 32'h2000_0040, 4'd1);
        slave_r(1, 4, 32'hB000, 3, 1, 3);
        chk("m1_beats", rbeats[1], 4);
        chk("no_err", err_o, 0);
        // length error: arlen=1 but rlast on the first beat
        wait_arready(0);
        slave_ar(0, 32'h1C00_0040, 4'd0);
        slave_r(0, 1, 32'hC000, 0, -1, 0);
        @(negedge clk);
        chk("len_err", err_o, 1);
        chk("len_err_idle", busy_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("err_sticky", err_o, 1);
        @(posedge clk); #1;
        // reset during beat 2 of a 4-beat DCache burst
        bus.m_araddr[63:32] = 32'h3000_0000;
        bus.m_arvalid[1] = 1'b1;
        exp_ar.push_back({4'd1, 32'h3000_0000, 8'd3, 3'd2});
        wait_arready(1);
        slave_ar(0, 32'h3000_0000, 4'd1);
        slave_r(1, 2, 32'hD000, 99, -1, 0);
        bus.s_rvalid = 1'b1;
        bus.s_rdata = 32'hD002;
        rst = 1'b1;
        @(negedge clk);
        chk("in_rst_rvalid", bus.m_rvalid, 0);
        chk("in_rst_rready", bus.s_rready, 0);
        chk("in_rst_busy", busy_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.s_rvalid = 1'b0;
        bus.s_rdata = '0;
        @(negedge clk);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_rvalid", bus.m_rvalid, 0);
        chk("mid_rst_rdata", bus.m_rdata, 0);
        chk("mid_rst_arvalid", bus.s_arvalid, 0);
        chk("mid_rst_araddr", bus.s_araddr, 0);
        chk("mid_rst_arid", bus.s_arid, 0);
        chk("mid_rst_err", err_o, 0);
        // a stray beat in IDLE is a protocol error
        @(posedge clk); #1;
        bus.s_rvalid = 1'b1;
        @(posedge clk); #1;
        bus.s_rvalid = 1'b0;
        @(negedge clk);
        chk("stray_err", err_o, 1);
        chk("ar_queue_empty", exp_ar.size(), 0);
        chk("r_queue_empty", exp_r.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
